// File: rtl/regbank_write_arbiter.sv
// regbank_write_arbiter: round-robin arbiter sharing one bank of 64-bit write-enabled registers.
// Ports: clk, reset (sync, active-high), arb_en (grant enable),
//   req_valid/req_addr/req_data/req_strb -> req_ready (one-hot grant, valid&ready = transfer),
//   reg_q (bank contents) -> reg_we (one-hot write enable), reg_d (shared write data),
//   err_addr (pulse on accepted out-of-range index), err_id (requester of last address error).
// Optional feature: define BYTE_MASK_EN for byte-strobed read-modify-write with forwarding.
module regbank_write_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int NUM_REGS = 8,
  parameter int ADDR_W   = 3
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       arb_en,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*ADDR_W-1:0]  req_addr,
  input  logic [NUM_REQ*64-1:0]      req_data,
  input  logic [NUM_REQ*8-1:0]       req_strb,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REGS*64-1:0]     reg_q,
  output logic [NUM_REGS-1:0]        reg_we,
  output logic [63:0]                reg_d,
  output logic                       err_addr,
  output logic [2:0]                 err_id
);
  localparam int PW = $clog2(NUM_REQ);
  logic [PW-1:0] rr_ptr, gnt_id;
  logic [PW:0] sum;
  logic [2*NUM_REQ-1:0] rot;
  logic gnt;
  logic [ADDR_W-1:0] sel_addr;
  logic [63:0] sel_data, wr_val;
  logic [7:0] sel_strb;
  logic in_range;
  logic [NUM_REGS-1:0] dec;
  // Rotate the request vector so bit 0 is the requester at rr_ptr; the first set bit wins.
  always_comb begin
    rot = {req_valid, req_valid} >> rr_ptr;
    gnt = 1'b0;
    gnt_id = rr_ptr;
    sum = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (!gnt && rot[i]) begin
        gnt = 1'b1;
        sum = (PW+1)'(rr_ptr) + (PW+1)'(i);
        gnt_id = (sum >= (PW+1)'(NUM_REQ)) ? PW'(sum - (PW+1)'(NUM_REQ)) : PW'(sum);
      end
    end
    gnt = gnt && arb_en && !reset;
  end
  assign req_ready = gnt ? (NUM_REQ'(1) << gnt_id) : '0;
  always_comb begin
    sel_addr = '0;
    sel_data = '0;
    sel_strb = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (req_ready[i]) begin
        sel_addr = req_addr[i*ADDR_W +: ADDR_W];
        sel_data = req_data[i*64 +: 64];
        sel_strb = req_strb[i*8 +: 8];
      end
    end
  end
  assign in_range = 32'(sel_addr) < 32'(NUM_REGS);
  assign dec = NUM_REGS'(1) << sel_addr;
`ifdef BYTE_MASK_EN
  logic [63:0] old;
  // A write to the same register already in the stage has not reached reg_q yet, so forward reg_d.
  always_comb begin
    old = '0;
    for (int r = 0; r < NUM_REGS; r++) begin
      if (dec[r]) old = reg_q[r*64 +: 64];
    end
    if (|(dec & reg_we)) old = reg_d;
    wr_val = sel_data;
    for (int k = 0; k < 8; k++) begin
      wr_val[k*8 +: 8] = sel_strb[k] ? sel_data[k*8 +: 8] : old[k*8 +: 8];
    end
  end
`else
  logic unused;
  assign wr_val = sel_data;
  assign unused = ^{reg_q, sel_strb};
`endif
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr   <= '0;
      reg_we   <= '0;
      reg_d    <= '0;
      err_addr <= 1'b0;
      err_id   <= '0;
    end else begin
      reg_we   <= (gnt && in_range) ? dec : '0;
      err_addr <= gnt && !in_range;
      if (gnt && in_range) reg_d <= wr_val;
      if (gnt && !in_range) err_id <= 3'(gnt_id);
      if (gnt) rr_ptr <= (gnt_id == PW'(NUM_REQ - 1)) ? '0 : gnt_id + 1'b1;
    end
  end
endmodule

// File: tb/tb_regbank_write_arbiter.sv
// tb_regbank_write_arbiter: scoreboard bench for regbank_write_arbiter (4 requesters, 6 registers).
module tb_regbank_write_arbiter;
  localparam int NR = 4;
  localparam int NG = 6;
  localparam int AW = 3;
  typedef struct packed {
    logic [NG-1:0] we;
    logic [63:0]   d;
    logic          err;
    logic [2:0]    id;
  } exp_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic arb_en = 1'b0;
  logic [NR-1:0] req_valid = '0;
  logic [NR*AW-1:0] req_addr = '0;
  logic [NR*64-1:0] req_data = '0;
  logic [NR*8-1:0] req_strb = '0;
  logic [NR-1:0] req_ready;
  logic [NG*64-1:0] reg_q;
  logic [NG-1:0] reg_we;
  logic [63:0] reg_d;
  logic err_addr;
  logic [2:0] err_id;
  logic [63:0] bank [NG] = '{default: '0};
  logic [NG-1:0] m_we = '0;
  logic [63:0] m_d = '0;
  logic [2:0] m_id = '0;
  exp_t q[$];
  int checks = 0;
  int errors = 0;

  regbank_write_arbiter #(.NUM_REQ(NR), .NUM_REGS(NG), .ADDR_W(AW)) dut (
    .clk(clk), .reset(reset), .arb_en(arb_en),
    .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data), .req_strb(req_strb),
    .req_ready(req_ready), .reg_q(reg_q), .reg_we(reg_we), .reg_d(reg_d),
    .err_addr(err_addr), .err_id(err_id)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    for (int r = 0; r < NG; r++) if (reg_we[r]) bank[r] <= reg_d;
  end

  always_comb begin
    reg_q = '0;
    for (int r = 0; r < NG; r++) reg_q[r*64 +: 64] = bank[r];
  end

  task automatic set_req(input int i, input logic [2:0] a, input logic [63:0] d, input logic [7:0] s);
    req_addr[i*AW +: AW] = a;
    req_data[i*64 +: 64] = d;
    req_strb[i*8 +: 8] = s;
  endtask

  task automatic push_cycle(input int g);
    exp_t x;
    logic [2:0] a;
    logic [63:0] v;
`ifdef BYTE_MASK_EN
    logic [63:0] old;
`endif
    x.we = '0;
    x.err = 1'b0;
    x.d = m_d;
    x.id = m_id;
    if (reset) begin
      x.d = '0;
      x.id = '0;
    end else if (g >= 0) begin
      a = req_addr[g*AW +: AW];
      v = req_data[g*64 +: 64];
      if (int'(a) < NG) begin
`ifdef BYTE_MASK_EN
        old = m_we[a] ? m_d : bank[a];
        for (int k = 0; k < 8; k++) if (!req_strb[g*8+k]) v[k*8 +: 8] = old[k*8 +: 8];
`endif
        x.we = NG'(1) << a;
        x.d = v;
      end else begin
        x.err = 1'b1;
        x.id = 3'(g);
      end
    end
    m_we = x.we;
    m_d = x.d;
    m_id = x.id;
    q.push_back(x);
  endtask

  task automatic test_reset;
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset = 1'b1;
      arb_en = 1'b1;
      req_valid = '1;
      for (int i = 0; i < NR; i++) set_req(i, 3'(i), 64'h100 + 64'(i), 8'hFF);
      #1;
      checks++;
      if (req_ready !== 4'b0000) begin
        errors++;
        $display("FAIL reset_ready: got %b want 0000", req_ready);
      end
      push_cycle(-1);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (reg_we !== e.we || reg_d !== e.d || err_addr !== e.err || err_id !== e.id) begin
        errors++;
        $display("FAIL reset_stage: got we=%b d=%h err=%b id=%0d want we=%b d=%h err=%b id=%0d",
                 reg_we, reg_d, err_addr, err_id, e.we, e.d, e.err, e.id);
      end
    end
    checks++;
    if (dut.rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL reset_ptr: got %0d want 0", dut.rr_ptr);
    end
  endtask

  task automatic test_single_write;
    exp_t e;
    logic [3:0] vld [2] = '{4'b0010, 4'b0000};
    int g [2] = '{1, -1};
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      reset = 1'b0;
      req_valid = vld[c];
      set_req(1, 3'd3, 64'hDEAD_BEEF_0000_0001, 8'hFF);
      #1;
      checks++;
      if (req_ready !== vld[c]) begin
        errors++;
        $display("FAIL single_ready: cycle %0d got %b want %b", c, req_ready, vld[c]);
      end
      push_cycle(g[c]);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (reg_we !== e.we || reg_d !== e.d || err_addr !== e.err || err_id !== e.id) begin
        errors++;
        $display("FAIL single_stage: cycle %0d got we=%b d=%h err=%b id=%0d want we=%b d=%h err=%b id=%0d",
                 c, reg_we, reg_d, err_addr, err_id, e.we, e.d, e.err, e.id);
      end
      checks++;
      if (reg_we !== (c == 0 ? 6'b001000 : 6'b000000) || reg_d !== 64'hDEAD_BEEF_0000_0001) begin
        errors++;
        $display("FAIL single_const: cycle %0d got we=%b d=%h", c, reg_we, reg_d);
      end
    end
  endtask

  task automatic test_out_of_range;
    exp_t e;
    logic [3:0] vld [4] = '{4'b0100, 4'b0000, 4'b1000, 4'b0010};
    int g [4] = '{2, -1, 3, 1};
    set_req(2, 3'd7, 64'h77, 8'hFF);
    set_req(3, 3'd6, 64'h66, 8'hFF);
    set_req(1, 3'd5, 64'h55, 8'hFF);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      req_valid = vld[c];
      #1;
      checks++;
      if (req_ready !== vld[c]) begin
        errors++;
        $display("FAIL oor_ready: cycle %0d got %b want %b", c, req_ready, vld[c]);
      end
      push_cycle(g[c]);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (reg_we !== e.we || reg_d !== e.d || err_addr !== e.err || err_id !== e.id) begin
        errors++;
        $display("FAIL oor_stage: cycle %0d got we=%b d=%h err=%b id=%0d want we=%b d=%h err=%b id=%0d",
                 c, reg_we, reg_d, err_addr, err_id, e.we, e.d, e.err, e.id);
      end
      if (c == 0) begin
        checks++;
        if (reg_we !== 6'b0 || err_addr !== 1'b1 || err_id !== 3'd2) begin
          errors++;
          $display("FAIL oor_const: got we=%b err=%b id=%0d want we=000000 err=1 id=2", reg_we, err_addr, err_id);
        end
      end
    end
    checks++;
    if (dut.rr_ptr !== 2'd2) begin
      errors++;
      $display("FAIL oor_ptr: got %0d want 2", dut.rr_ptr);
    end
  endtask

  task automatic test_arb_en;
    exp_t e;
    logic [3:0] rdy;
    int g;
    for (int i = 0; i < NR; i++) set_req(i, 3'(i), 64'h1000 + 64'(i), 8'hFF);
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      req_valid = '1;
      arb_en = (c >= 5);
      rdy = (c == 5) ? 4'b0100 : (c == 6) ? 4'b1000 : 4'b0000;
      g = (c == 5) ? 2 : (c == 6) ? 3 : -1;
      #1;
      checks++;
      if (req_ready !== rdy) begin
        errors++;
        $display("FAIL arb_en_ready: cycle %0d got %b want %b", c, req_ready, rdy);
      end
      push_cycle(g);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (reg_we !== e.we || reg_d !== e.d || err_addr !== e.err || err_id !== e.id) begin
        errors++;
        $display("FAIL arb_en_stage: cycle %0d got we=%b d=%h err=%b id=%0d want we=%b d=%h err=%b id=%0d",
                 c, reg_we, reg_d, err_addr, err_id, e.we, e.d, e.err, e.id);
      end
      if (c < 5) begin
        checks++;
        if (dut.rr_ptr !== 2'd2) begin
          errors++;
          $display("FAIL arb_en_ptr: cycle %0d got %0d want 2", c, dut.rr_ptr);
        end
      end
    end
  endtask

  task automatic test_reset_midstream;
    exp_t e;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      req_valid = '1;
      reset = (c == 1);
      #1;
      checks++;
      if (req_ready !== (c == 0 ? 4'b0001 : 4'b0000)) begin
        errors++;
        $display("FAIL midreset_ready: cycle %0d got %b", c, req_ready);
      end
      push_cycle(c == 0 ? 0 : -1);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (reg_we !== e.we || reg_d !== e.d || err_addr !== e.err || err_id !== e.id) begin
        errors++;
        $display("FAIL midreset_stage: cycle %0d got we=%b d=%h err=%b id=%0d want we=%b d=%h err=%b id=%0d",
                 c, reg_we, reg_d, err_addr, err_id, e.we, e.d, e.err, e.id);
      end
    end
    checks++;
    if (reg_we !== 6'b0 || reg_d !== 64'h0 || dut.rr_ptr !== 2'd0) begin
      errors++;
      $display("FAIL midreset_const: got we=%b d=%h ptr=%0d want 0,0,0", reg_we, reg_d, dut.rr_ptr);
    end
  endtask

  task automatic test_fairness;
    exp_t e;
    logic [3:0] rdy;
    for (int i = 0; i < NR; i++) set_req(i, 3'(i + 1), 64'hF000 + 64'(i), 8'hFF);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      reset = 1'b0;
      req_valid = '1;
      rdy = 4'b0001 << (c % 4);
      #1;
      checks++;
      if (req_ready !== rdy) begin
        errors++;
        $display("FAIL fair_ready: cycle %0d got %b want %b", c, req_ready, rdy);
      end
      push_cycle(c % 4);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (reg_we !== e.we || reg_d !== e.d || err_addr !== e.err || err_id !== e.id) begin
        errors++;
        $display("FAIL fair_stage: cycle %0d got we=%b d=%h err=%b id=%0d want we=%b d=%h err=%b id=%0d",
                 c, reg_we, reg_d, err_addr, err_id, e.we, e.d, e.err, e.id);
      end
    end
  endtask

  task automatic test_back_to_back_strobe;
    exp_t e;
    logic [3:0] vld [6] = '{4'b0001, 4'b0001, 4'b0001, 4'b0000, 4'b0001, 4'b0000};
    logic [63:0] dat [6] = '{64'h0, 64'hFF, 64'hAA00, 64'h0, 64'h1234, 64'h0};
    logic [7:0] stb [6] = '{8'hFF, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00};
`ifdef BYTE_MASK_EN
    logic [63:0] want [6] = '{64'h0, 64'hFF, 64'hAAFF, 64'hAAFF, 64'hAAFF, 64'hAAFF};
`else
    logic [63:0] want [6] = '{64'h0, 64'hFF, 64'hAA00, 64'hAA00, 64'h1234, 64'h1234};
`endif
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      req_valid = vld[c];
      set_req(0, 3'd0, dat[c], stb[c]);
      #1;
      checks++;
      if (req_ready !== vld[c]) begin
        errors++;
        $display("FAIL strobe_ready: cycle %0d got %b want %b", c, req_ready, vld[c]);
      end
      push_cycle(vld[c][0] ? 0 : -1);
      @(posedge clk); #1;
      e = q.pop_front();
      checks++;
      if (reg_we !== e.we || reg_d !== e.d || err_addr !== e.err || err_id !== e.id) begin
        errors++;
        $display("FAIL strobe_stage: cycle %0d got we=%b d=%h err=%b id=%0d want we=%b d=%h err=%b id=%0d",
                 c, reg_we, reg_d, err_addr, err_id, e.we, e.d, e.err, e.id);
      end
      checks++;
      if (reg_d !== want[c] || reg_we !== (vld[c][0] ? 6'b000001 : 6'b000000)) begin
        errors++;
        $display("FAIL strobe_const: cycle %0d got we=%b d=%h want d=%h", c, reg_we, reg_d, want[c]);
      end
    end
  endtask

  initial begin
    test_reset;
    test_single_write;
    test_out_of_range;
    test_arb_en;
    test_reset_midstream;
    test_fairness;
    test_back_to_back_strobe;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/regbank_write_arbiter.md
# regbank_write_arbiter

Round-robin write arbiter that shares one bank of 64-bit write-enabled registers (`register_with_we` instances) between several requesters. It accepts one write per cycle through a valid/ready handshake and decodes the register index. It drives the bank's per-register write enables and the shared 64-bit data bus from a registered write stage. It sits between the bus-side masters and the configuration/status register bank of the SoC.

## Interface
- `NUM_REQ`, default 4: number of requesters, 2..8.
- `NUM_REGS`, default 8: registers in the bank, 2..64.
- `ADDR_W`, default 3: register index width; must be ≥ clog2(NUM_REGS).

- `clk`  in  1: single clock; all state updates on its rising edge.
- `reset`  in  1: synchronous, active-high reset.
- `arb_en`  in  1: when 0, no request is granted.
- `req_valid`  in  NUM_REQ: per-requester write request.
- `req_addr`  in  NUM_REQ*ADDR_W: flattened register indices, requester i at [i*ADDR_W +: ADDR_W].
- `req_data`  in  NUM_REQ*64: flattened write data.
- `req_strb`  in  NUM_REQ*8: flattened byte strobes. Used only with BYTE_MASK_EN.
- `req_ready`  out  NUM_REQ: one-hot grant; a transfer occurs when valid&ready.
- `reg_q`  in  NUM_REGS*64: current bank contents. Used only with BYTE_MASK_EN.
- `reg_we`  out  NUM_REGS: one-hot or zero write enables to the bank.
- `reg_d`  out  64: shared write data to all bank registers.
- `err_addr`  out  1: one-cycle pulse when an accepted request carried an index ≥ NUM_REGS.
- `err_id`  out  3: requester index of the last address error.

## Operation
- Grant logic is combinational from `req_valid`, `rr_ptr` and `arb_en`. The scan starts at `rr_ptr` and moves upward modulo NUM_REQ. The first valid requester gets `req_ready`. At most one ready bit is high.
- `req_ready` is 0 while `reset` is high or `arb_en` is 0.
- On a transfer from requester g:
  - `rr_ptr` ← (g+1) mod NUM_REQ.
  - If there is no transfer, `rr_ptr` holds.
- Write stage, registered:
  - On a transfer with addr < NUM_REGS: next cycle `reg_we` = 1<<addr, and `reg_d` = the write value.
  - Otherwise `reg_we` = 0 and `reg_d` holds its previous value.
- Out-of-range index:
  - The request is still accepted, so the requester is not stalled.
  - No write is issued.
  - `err_addr` pulses in the same cycle the write would have appeared.
  - `err_id` ← g, and it holds until the next error.
- Requesters must hold valid/addr/data/strb stable until accepted. Dropping valid before acceptance is permitted and simply withdraws the request.
- Reset values:
  - `rr_ptr` = 0.
  - `reg_we` = 0.
  - `reg_d` = 64'h0.
  - `err_addr` = 0.
  - `err_id` = 0.
- Reset asserted mid-operation discards the pending write stage: `reg_we` = 0 in the cycle after reset is sampled.

## Timing
- Grant is zero-latency: ready is visible in the same cycle as valid.
- Write to bank: `reg_we`/`reg_d` are asserted one cycle after acceptance. The bank register updates at the following edge, so the new `reg_q` is visible two cycles after acceptance.
- Throughput: one accepted write per cycle sustained, with no bubbles between different requesters.
- Fairness: with all requesters continuously valid, each is granted exactly once every NUM_REQ cycles.
- Requesters can lose arbitration repeatedly only while other requesters are ahead of them in rotation.

## Configuration
- `BYTE_MASK_EN` defined:
  - Write value = per byte k, `req_strb[k]` ? new data byte : old byte.
  - The old value is taken from `reg_q[addr]`. Exception: if the write stage currently holds a write to the same addr (`reg_we[addr]` = 1), the old value is taken from `reg_d` instead (forwarding).
  - A strobe of 8'h00 still issues `reg_we` with unchanged data.
- `BYTE_MASK_EN` undefined:
  - Write value = full `req_data`.
  - `req_strb` and `reg_q` are unused and must not affect any output.

## Test plan
- Reset then a single write: after release, requester 1 sends addr 3, data 64'hDEAD_BEEF_0000_0001. Required: ready1 in the same cycle; next cycle `reg_we` = 8'b0000_1000 and `reg_d` = 64'hDEAD_BEEF_0000_0001; `reg_we` = 0 after that.
- Round-robin fairness: all 4 requesters hold valid for 8 cycles. Required grant order is 0,1,2,3,0,1,2,3, with zero idle cycles.
- Out of range: with NUM_REGS = 6, requester 2 sends addr 7. Required: it is accepted; next cycle `reg_we` = 0, `err_addr` = 1 for one cycle, and `err_id` = 2.
- `arb_en` = 0 with all requesters valid: no ready bits for 5 cycles and `rr_ptr` unchanged. Re-enabling grants the requester at `rr_ptr` first.
- Reset mid-stream: reset asserted in the cycle after an acceptance. Required: `reg_we` = 0 next cycle, `rr_ptr` = 0, and `reg_d` = 0.
- BYTE_MASK_EN back-to-back: reg 0 = 64'h0. Write 1 has strb 8'h01 and data 64'hFF. Write 2 goes to the same reg in the next cycle with strb 8'h02 and data 64'hAA00. Required: the second `reg_d` = 64'hAA_FF, produced by forwarding.
